// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg
// Shared definitions for the ADC AXI-Stream capture path: capture state
// encodings and the helper that turns a programmed sample count into the
// capture target (0 selects full BRAM depth).
// No ports (package).

package adc_capture_pkg;

    localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [1:0] ST_ARMED_ENC   = 2'd1;
    localparam logic [1:0] ST_CAPTURE_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE_ENC,
        ARMED   = ST_ARMED_ENC,
        CAPTURE = ST_CAPTURE_ENC,
        DONE    = ST_DONE_ENC
    } cap_state_e;

    // nsamples == 0 encodes a full-depth capture of 2^addr_width words.
    function automatic logic [31:0] calc_target(input logic [31:0] nsamples,
                                                input int addr_width);
        if (nsamples == 32'd0)
            return 32'd1 << addr_width;
        return nsamples;
    endfunction

endpackage

// File: rtl/capture_decim_gate.sv
// capture_decim_gate
// Beat-qualifying phase counter used when CAPTURE_DECIM_EN is defined.
// Passes every (decim+1)-th beat, starting with the first beat after clear.
// Ports:
//   clk, rst  - clock and async active-high reset
//   clear     - holds the phase at zero (outside the capture window / abort)
//   beat      - a valid beat inside the capture window
//   decim     - decimation factor minus one
//   take      - beat selected for writing

module capture_decim_gate
    import adc_capture_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       beat,
    input  logic [7:0] decim,
    output logic       take
);

    logic [7:0] phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (clear) begin
            phase <= '0;
        end else if (beat) begin
            // >= keeps the counter bounded if decim shrinks mid-capture
            phase <= (phase >= decim) ? 8'd0 : phase + 8'd1;
        end
    end

    assign take = beat && (phase == 8'd0);

endmodule

// File: rtl/adc_axis_capture.sv
// adc_axis_capture
// Sinks one ADC AXI-Stream channel and, once armed and triggered, writes a
// programmed number of samples into a capture BRAM (registered write port).
// Optional build macro: CAPTURE_DECIM_EN adds decim[7:0] and writes only
// every (decim+1)-th valid beat.
//
// state   | meaning
// IDLE    | waiting for arm; beats discarded, trigger ignored
// ARMED   | target latched, waiting for trigger
// CAPTURE | writing valid beats until count reaches target
// DONE    | capture complete, count held, arm re-arms
//
// Ports:
//   clk, rst            - ADC clock, async active-high reset
//   s_axis_tdata/tvalid - ADC sample stream; s_axis_tready is 1 outside reset
//   arm, abort, trigger - single-cycle control pulses
//   nsamples            - capture length, 0 = full depth
//   bram_addr/din/we    - capture BRAM write port
//   busy, done, count   - status; overrun flags a trigger during CAPTURE

module adc_axis_capture
    import adc_capture_pkg::*;
#(
    parameter int DATAWIDTH = 64,
    parameter int ADDRWIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 arm,
    input  logic                 abort,
    input  logic                 trigger,
    input  logic [ADDRWIDTH:0]   nsamples,
`ifdef CAPTURE_DECIM_EN
    input  logic [7:0]           decim,
`endif
    output logic [ADDRWIDTH-1:0] bram_addr,
    output logic [DATAWIDTH-1:0] bram_din,
    output logic                 bram_we,
    output logic                 busy,
    output logic                 done,
    output logic [ADDRWIDTH:0]   count,
    output logic                 overrun
);

    localparam int CW = ADDRWIDTH + 1;

    cap_state_e    state_q, state_d;
    logic [CW-1:0] target_q, count_q, count_inc;
    logic          overrun_q;
    logic          window, beat, take, arm_load, overrun_set;

    // The trigger cycle in ARMED already belongs to the capture window so a
    // beat arriving with trigger becomes the first sample.
    assign window      = (state_q == CAPTURE) || ((state_q == ARMED) && trigger);
    assign beat        = window && s_axis_tvalid && !abort;
    assign count_inc   = count_q + CW'(1);
    assign arm_load    = arm && !abort && ((state_q == IDLE) || (state_q == DONE));
    assign overrun_set = trigger && !abort && (state_q == CAPTURE);

`ifdef CAPTURE_DECIM_EN
    capture_decim_gate u_decim_gate (
        .clk   (clk),
        .rst   (rst),
        .clear (!window || abort),
        .beat  (beat),
        .decim (decim),
        .take  (take)
    );
`else
    assign take = beat;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (arm)     state_d = ARMED;
            ARMED:   if (trigger) state_d = CAPTURE;
            CAPTURE: state_d = CAPTURE;
            DONE:    if (arm)     state_d = ARMED;
            default: state_d = IDLE;
        endcase
        // Last sample: DONE lands on the same cycle its registered write issues.
        if (take && (count_inc == target_q))
            state_d = DONE;
        if (abort)
            state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
        end else begin
            bram_we <= take;
            if (take) begin
                bram_addr <= count_q[ADDRWIDTH-1:0];
                bram_din  <= s_axis_tdata;
                count_q   <= count_inc;
            end
            if (arm_load) begin
                target_q  <= CW'(calc_target(32'(nsamples), ADDRWIDTH));
                count_q   <= '0;
                overrun_q <= 1'b0;
            end else if (overrun_set) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign s_axis_tready = ~rst;
    assign busy          = (state_q == ARMED) || (state_q == CAPTURE);
    assign done          = (state_q == DONE);
    assign count         = count_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_adc_axis_capture.sv
module tb_adc_axis_capture;

    localparam int AW = 4;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          arm, abort, trigger;
    logic [AW:0]   nsamples;
`ifdef CAPTURE_DECIM_EN
    logic [7:0]    decim;
`endif
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic          bram_we;
    logic          busy, done, overrun;
    logic [AW:0]   count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0;

    typedef struct packed {
        logic [31:0]   c;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t wq[$];

    adc_axis_capture #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .arm           (arm),
        .abort         (abort),
        .trigger       (trigger),
        .nsamples      (nsamples),
`ifdef CAPTURE_DECIM_EN
        .decim         (decim),
`endif
        .bram_addr     (bram_addr),
        .bram_din      (bram_din),
        .bram_we       (bram_we),
        .busy          (busy),
        .done          (done),
        .count         (count),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bram_we === 1'b1) wq.push_back('{32'(cyc), bram_addr, bram_din});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        s_axis_tvalid = 1'b0;
        arm = 1'b0;
        abort = 1'b0;
        trigger = 1'b0;
    endtask

    task automatic do_arm(input logic [AW:0] n);
        arm = 1'b1;
        nsamples = n;
        tick();
        arm = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int n, input logic [63:0] dbase);
        chk({tag, " nwrites"}, 64'(wq.size()), 64'(n));
        for (int i = 0; i < n && i < wq.size(); i++) begin
            chk({tag, " addr"}, 64'(wq[i].a), 64'(i));
            chk({tag, " data"}, wq[i].d, dbase + 64'(i));
        end
    endtask

    initial begin
        rst = 1'b1;
        s_axis_tdata = '0;
        nsamples = '0;
`ifdef CAPTURE_DECIM_EN
        decim = 8'd0;
`endif
        quiet();
        #12;
        chk("rst bram_we", 64'(bram_we), 0);
        chk("rst bram_addr", 64'(bram_addr), 0);
        chk("rst bram_din", bram_din, 0);
        chk("rst count", 64'(count), 0);
        chk("rst overrun", 64'(overrun), 0);
        chk("rst busy", 64'(busy), 0);
        chk("rst done", 64'(done), 0);
        chk("rst tready", 64'(s_axis_tready), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("tready after rst", 64'(s_axis_tready), 1);

        // 1: basic capture, 8 continuous beats
        wq.delete();
        do_arm(5'd8);
        chk("t1 busy armed", 64'(busy), 1);
        t0 = cyc;
        for (int i = 0; i < 11; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata = 64'h100 + 64'(i);
            trigger = (i == 0);
            tick();
        end
        quiet();
        tick();
        check_writes("t1", 8, 64'h100);
        for (int i = 0; i < 8 && i < wq.size(); i++)
            chk("t1 latency", 64'(wq[i].c), 64'(t0 + 1 + i));
        chk("t1 done", 64'(done), 1);
        chk("t1 count", 64'(count), 8);
        chk("t1 busy", 64'(busy), 0);

        // 2: gapped valid 1,0,0,1,1,0,1
        wq.delete();
        do_arm(5'd4);
        for (int i = 0; i < 7; i++) begin
            s_axis_tvalid = (i == 0 || i == 3 || i == 4 || i == 6);
            s_axis_tdata = 64'h200 + 64'(i);
            trigger = (i == 0);
            tick();
        end
        quiet();
        tick();
        chk("t2 nwrites", 64'(wq.size()), 4);
        if (wq.size() == 4) begin
            chk("t2 d0", wq[0].d, 64'h200);
            chk("t2 d1", wq[1].d, 64'h203);
            chk("t2 d2", wq[2].d, 64'h204);
            chk("t2 d3", wq[3].d, 64'h206);
            chk("t2 a3", 64'(wq[3].a), 3);
        end
        chk("t2 done", 64'(done), 1);
        chk("t2 count", 64'(count), 4);

        // 3: full depth (nsamples = 0 -> 16 words)
        wq.delete();
        do_arm(5'd0);
        for (int i = 0; i < 20; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata = 64'h300 + 64'(i);
            trigger = (i == 0);
            tick();
        end
        quiet();
        tick();
        check_writes("t3", 16, 64'h300);
        chk("t3 count", 64'(count), 16);
        chk("t3 done", 64'(done), 1);

        // 4: overrun, then abort+arm together
        wq.delete();
        do_arm(5'd10);
        for (int i = 0; i < 5; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata = 64'h400 + 64'(i);
            trigger = (i == 0 || i == 3);
            tick();
        end
        chk("t4 overrun", 64'(overrun), 1);
        chk("t4 busy continues", 64'(busy), 1);
        trigger = 1'b0;
        s_axis_tdata = 64'h405;
        abort = 1'b1;
        arm = 1'b1;
        tick();
        abort = 1'b0;
        arm = 1'b0;
        chk("t4 busy after abort", 64'(busy), 0);
        chk("t4 done after abort", 64'(done), 0);
        for (int i = 0; i < 3; i++) tick();
        quiet();
        tick();
        check_writes("t4", 5, 64'h400);
        chk("t4 count kept", 64'(count), 5);
        chk("t4 overrun kept", 64'(overrun), 1);
        do_arm(5'd2);
        chk("t4 overrun cleared", 64'(overrun), 0);
        chk("t4 count cleared", 64'(count), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // 5: reset mid-capture
        wq.delete();
        do_arm(5'd8);
        for (int i = 0; i < 3; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata = 64'h500 + 64'(i);
            trigger = (i == 0);
            tick();
        end
        trigger = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5 writes before rst", 64'(wq.size()), 3);
        chk("t5 bram_we", 64'(bram_we), 0);
        chk("t5 bram_addr", 64'(bram_addr), 0);
        chk("t5 bram_din", bram_din, 0);
        chk("t5 count", 64'(count), 0);
        chk("t5 busy", 64'(busy), 0);
        chk("t5 done", 64'(done), 0);
        chk("t5 overrun", 64'(overrun), 0);
        chk("t5 tready", 64'(s_axis_tready), 0);
        tick();
        tick();
        rst = 1'b0;
        wq.delete();
        for (int i = 0; i < 5; i++) begin
            s_axis_tvalid = 1'b1;
            trigger = 1'b1;
            tick();
        end
        quiet();
        tick();
        chk("t5 no write w/o arm", 64'(wq.size()), 0);
        chk("t5 idle busy", 64'(busy), 0);

`ifdef CAPTURE_DECIM_EN
        // 6: decimation by 3
        wq.delete();
        decim = 8'd2;
        do_arm(5'd3);
        for (int i = 0; i < 9; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata = 64'(i);
            trigger = (i == 0);
            tick();
        end
        quiet();
        tick();
        chk("t6 nwrites", 64'(wq.size()), 3);
        for (int i = 0; i < 3 && i < wq.size(); i++) begin
            chk("t6 addr", 64'(wq[i].a), 64'(i));
            chk("t6 data", wq[i].d, 64'(3 * i));
        end
        chk("t6 done", 64'(done), 1);
        decim = 8'd0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
